// File: rtl/spi_mx.sv
// spi_mx: multi-slave SPI master, one DATA_W-bit full-duplex word per start,
// any CPOL/CPHA mode, MSB- or LSB-first, optional select hold for bursts.
module spi_mx #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DVSR_W = 16,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              hold_cs,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] ss_n,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              done
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, P0, P1} state_t;

    state_t            state;
    logic [DVSR_W-1:0] cnt;
    logic [DVSR_W-1:0] dvsr_r;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;
    logic              hold_r;
    logic [CS_W-1:0]   cs_r;
    logic              held;
    logic [CS_W-1:0]   held_cs;
    logic              half_end;

    // Out-of-range indices match no line, leaving every select high.
    function automatic logic [NUM_CS-1:0] sel_mask(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == CS_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic tx_bit(input logic [DATA_W-1:0] w,
                                    input logic lsb,
                                    input logic [BW-1:0] i);
        return lsb ? w[i] : w[LAST - i];
    endfunction

    assign half_end = (cnt == dvsr_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dvsr_r  <= '0;
            bit_cnt <= '0;
            tx_r    <= '0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            lsb_r   <= 1'b0;
            hold_r  <= 1'b0;
            cs_r    <= '0;
            held    <= 1'b0;
            held_cs <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= '1;
            dout    <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (start) begin
                        tx_r    <= din;
                        dvsr_r  <= dvsr;
                        cpol_r  <= cpol;
                        cpha_r  <= cpha;
                        lsb_r   <= lsb_first;
                        cs_r    <= cs_sel;
                        hold_r  <= hold_cs;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        mosi    <= tx_bit(din, lsb_first, '0);
                        // A still-held select to the same slave needs no setup time.
                        if (held && cs_sel == held_cs) begin
                            state <= P0;
                            sclk  <= cpol ^ cpha;
                        end else begin
                            state <= SETUP;
                            ss_n  <= sel_mask(cs_sel);
                        end
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        cnt   <= '0;
                        state <= P0;
                        sclk  <= cpol_r ^ cpha_r;
                    end else begin
                        cnt <= cnt + DVSR_W'(1);
                    end
                end
                P0: begin
                    if (half_end) begin
                        cnt   <= '0;
                        state <= P1;
                        sclk  <= cpol_r ^ ~cpha_r;
                        dout  <= lsb_r ? {miso, dout[DATA_W-1:1]}
                                       : {dout[DATA_W-2:0], miso};
                    end else begin
                        cnt <= cnt + DVSR_W'(1);
                    end
                end
                P1: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (bit_cnt == LAST) begin
                            state   <= IDLE;
                            done    <= 1'b1;
                            ready   <= 1'b1;
                            sclk    <= cpol_r;
                            held    <= hold_r;
                            held_cs <= cs_r;
                            if (!hold_r) ss_n <= '1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= P0;
                            sclk    <= cpol_r ^ cpha_r;
                            mosi    <= tx_bit(tx_r, lsb_r, bit_cnt + BW'(1));
                        end
                    end else begin
                        cnt <= cnt + DVSR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_mx.md
# spi_mx

Parametrised multi-slave SPI master, successor to the single-slave 8-bit `spi_m`. Serialises one `DATA_W`-bit word per `start`, full duplex, in any of the four CPOL/CPHA modes, MSB- or LSB-first. It drives `NUM_CS` active-low slave selects with optional select hold across back-to-back words for burst transactions. It sits between a host register interface and the off-chip SPI pins.

## Interface
- `DATA_W`, 8: bits per transfer (≥2).
- `NUM_CS`, 4: number of slave-select lines (≥1).
- `DVSR_W`, 16: width of `dvsr`.
- `CS_W`, `$clog2(NUM_CS)` (min 1): width of `cs_sel`.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  transfer request; accepted only when `ready`=1.
- `din`  in  DATA_W  word to transmit.
- `dvsr`  in  DVSR_W  half-period of sclk = `dvsr`+1 clk cycles.
- `cpol`  in  1  clock idle level.
- `cpha`  in  1  clock phase (0: sample on leading edge, 1: sample on trailing edge).
- `lsb_first`  in  1  1 = LSB shifted first.
- `cs_sel`  in  CS_W  target slave index.
- `hold_cs`  in  1  keep the select asserted after this word.
- `miso`  in  1  serial data from slave.
- `sclk`  out  1  SPI clock, registered.
- `mosi`  out  1  serial data to slave, registered.
- `ss_n`  out  NUM_CS  active-low selects, registered.
- `dout`  out  DATA_W  received word.
- `ready`  out  1  idle, can accept `start`.
- `done`  out  1  one-cycle pulse, word complete.

## Operation
- Reset values: `sclk`=0, `mosi`=0, `ss_n`=all 1, `dout`=0, `ready`=1, `done`=0. State goes to IDLE, held-select flag is cleared, counters are 0.
- The `start` && `ready` edge latches `din`, `dvsr`, `cpol`, `cpha`, `lsb_first`, `cs_sel`, `hold_cs`. All later behaviour uses the latched copies. `ready` goes to 0 the next cycle.
- States: IDLE → SETUP → P0 → P1 → (P0 for the next bit | IDLE after bit DATA_W-1).
- IDLE:
  - `ready`=1.
  - `sclk` <= `cpol` input every cycle.
  - `mosi` holds its last value.
- SETUP:
  - Lasts `dvsr`+1 cycles.
  - `ss_n[cs_sel]`=0, `sclk`=cpol.
  - `mosi` = first bit.
  - SETUP is skipped (go straight to P0) if the select is still held and the latched `cs_sel` equals the held index.
  - If the select is held and `cs_sel` differs, the old select releases on entry to SETUP.
- P0 and P1:
  - Each half lasts `dvsr`+1 cycles.
  - `sclk` = cpol^cpha in P0 and cpol^~cpha in P1.
  - `mosi` updates to the current bit on entry to P0. For the first bit with cpha=0, it is already valid from SETUP.
  - `miso` is sampled on the last cycle of P0, which is the P0→P1 boundary.
- Bit order:
  - MSB-first: tx index DATA_W-1 down to 0. The received bit shifts in at `dout`[0] (left shift).
  - LSB-first: tx index 0 upward. The received bit shifts in at `dout`[DATA_W-1] (right shift).
  - In both cases `dout` ends in natural bit positions.
- Completion:
  - After the last P1, go to IDLE.
  - In that cycle `done`=1, `ready`=1, and `dout` holds the final word.
  - `sclk` returns to cpol.
  - If hold_cs=0, `ss_n` goes all 1 and the held flag clears. Otherwise `ss_n[cs_sel]` stays 0 and the held flag is set.
- Out-of-range `cs_sel` (≥NUM_CS): the transfer runs normally with all `ss_n`=1.
- `start` while `ready`=0 is ignored. It is not queued.
- `rst` mid-transfer: the next cycle has reset values. No `done` is issued and a held select is dropped.
- `dvsr`=0 is legal: sclk = clk/2.

## Timing
- From the accepting edge to `done`: (dvsr+1)·(2·DATA_W+1) cycles with SETUP, or (dvsr+1)·2·DATA_W cycles in a held burst.
- `ready`=0 for all of those cycles except the `done` cycle. A `start` in the `done` cycle is accepted.
- Outputs are glitch-free, with exactly 2·DATA_W `sclk` toggles per word.
- `dout` is stable from `done` until the next accepted `start` completes its first sample.

## Test plan
- Mode 0, DATA_W=8, dvsr=1, din=0xA5, `miso` looped to `mosi`, cs_sel=1 → `ss_n`=4'b1101 during the transfer, 16 sclk toggles, `done` 34 cycles after accept, dout=0xA5, `ss_n`=4'hF in the `done` cycle.
- Mode 3, lsb_first=1, dvsr=49, din=0x64, slave model drives 0x3C LSB-first and samples on the rising edge → slave receives 0x64, dout=0x3C, sclk idles high.
- Modes 1 and 2 against a per-mode slave model, din=0xC3, slave word 0x5A → both directions exact, miso sampled only at the P0→P1 boundary.
- Burst: hold_cs=1 word 0x11 then hold_cs=0 word 0x22 to cs_sel=2, dvsr=0 → `ss_n`[2] low continuously, second word done 16 cycles after its accept, release after word 2.
- Select switch: hold_cs=1 to cs 0, then start to cs 3 → `ss_n`[0] rises when the new SETUP begins, `ss_n`[3] falls, SETUP present.
- Reset at bit 4 of a transfer, plus `start` pulses while busy → busy starts ignored. After reset: sclk=0, ss_n all 1, ready=1, no `done`.
